// File: rtl/add_rr_arbiter.sv
// -----------------------------------------------------------------------------
// add_rr_arbiter
//   Shares one WIDTH-bit adder (sum + {V,C,N,Z} flags) among NREQ requesters.
//   Requests are arbitrated round-robin over valid/ready channels. The granted
//   operation is computed combinationally and captured in a single-entry
//   output register, which is presented on a valid/ready response channel
//   tagged with the owning requester's index.
//
// Ports
//   CLK         rising-edge clock
//   ASYNCRESET  asynchronous, active-high reset
//   clk_en      global enable; low freezes every register and blocks grants
//   req_valid   per-requester request valid                    [NREQ]
//   req_ready   per-requester grant, one-hot or zero (comb.)   [NREQ]
//   req_a       operand a, requester i at [i*WIDTH +: WIDTH]   [NREQ*WIDTH]
//   req_b       operand b, packed like req_a                   [NREQ*WIDTH]
//   rsp_valid   response valid
//   rsp_ready   response consumer ready
//   rsp_id      index of the requester owning the response     [IDW]
//   rsp_data    sum[WIDTH-1:0]                                 [WIDTH]
//   rsp_flags   {V,C,N,Z}                                      [4]
//   op_count    saturating count of accepted requests          [CNTW]
// -----------------------------------------------------------------------------
module add_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 16
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    input  logic                  clk_en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [3:0]            rsp_flags,
    output logic [CNTW-1:0]       op_count
);

    // Registered state
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [CNTW-1:0]  op_count_q,  op_count_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;

    // Arbitration results
    logic             slot_free;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant;

    // Datapath
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_data;
    logic             flag_v, flag_c, flag_n, flag_z;

    // The slot can take a new result when it is empty or being drained in
    // this same cycle, so a consume and an accept overlap with no bubble.
    assign slot_free = clk_en & (~rsp_valid_q | rsp_ready);

    // Round-robin priority search starting at ptr_q.
    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned infers a latch.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant       = '0;
        idx         = 0;
        if (slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant_found && req_valid[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(idx);
                end
            end
        end
        if (grant_found) grant[grant_idx] = 1'b1;
    end

    // Grants are forced off while reset is held, independent of the clock.
    assign req_ready = ASYNCRESET ? '0 : grant;

    // Shared adder on the granted operands.
    always_comb begin
        op_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
        op_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
        sum      = {1'b0, op_a} + {1'b0, op_b};
        sum_data = sum[WIDTH-1:0];
        flag_c   = sum[WIDTH];
        flag_z   = (sum_data == '0);
        flag_n   = sum_data[WIDTH-1];
        // Signed overflow: like-signed operands produced an opposite-signed result.
        flag_v   = (op_a[WIDTH-1] & op_b[WIDTH-1] & ~flag_n) |
                   (~op_a[WIDTH-1] & ~op_b[WIDTH-1] & flag_n);
    end

    // Next-state logic for the output slot, pointer and counter.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        op_count_d  = op_count_q;
        ptr_d       = ptr_q;
        if (grant_found) begin
            // grant_found implies slot_free, hence clk_en is high here.
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = sum_data;
            rsp_flags_d = {flag_v, flag_c, flag_n, flag_z};
            ptr_d       = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + IDW'(1);
            if (op_count_q != {CNTW{1'b1}}) op_count_d = op_count_q + CNTW'(1);
        end else if (clk_en && rsp_valid_q && rsp_ready) begin
            // Consume with nothing to replace it: payload holds its last value.
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            op_count_q  <= op_count_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_add_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_rr_arbiter
//   Directed testbench for add_rr_arbiter (NREQ=4, WIDTH=16). A table of
//   hand-computed vectors covers single requests and flag corners; short
//   hand-written sequences cover round-robin order, backpressure, clk_en
//   freeze and asynchronous reset in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_add_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;
    localparam int CNTW  = 16;

    logic                  CLK = 1'b0;
    logic                  ASYNCRESET;
    logic                  clk_en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic [3:0]            rsp_flags;
    logic [CNTW-1:0]       op_count;

    add_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .op_count   (op_count)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESET = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        clk_en     = 1'b1;
        req_a      = '0;
        req_b      = '0;
        tick();
        tick();
        ASYNCRESET = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic rv, input logic [1:0] id,
                             input logic [15:0] data, input logic [3:0] flags, input logic [15:0] cnt);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check({tag, ".rsp_id"},    32'(rsp_id),    32'(id));
        check({tag, ".rsp_data"},  32'(rsp_data),  32'(data));
        check({tag, ".rsp_flags"}, 32'(rsp_flags), 32'(flags));
        check({tag, ".op_count"},  32'(op_count),  32'(cnt));
    endtask

    // One vector: inputs for this cycle, expected combinational grant in this
    // cycle, and expected registered response state visible in this cycle.
    typedef struct {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic        rr;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    logic [15:0] held_data;
    logic [1:0]  held_id;
    int          prev_g;

    initial begin
        // ptr starts at 0; each row's expected grant follows the pointer
        // left by the previous grant.
        vecs[0] = '{4'b0001, {48'h0, 16'h0003}, {48'h0, 16'h0004}, 1'b1,
                    4'b0001, 1'b0, 2'd0, 16'h0000, 4'h0, 16'd0};
        vecs[1] = '{4'b0000, 64'h0, 64'h0, 1'b1,
                    4'b0000, 1'b1, 2'd0, 16'h0007, 4'h0, 16'd1};
        vecs[2] = '{4'b0100, {16'h0, 16'h7FFF, 32'h0}, {16'h0, 16'h0001, 32'h0}, 1'b1,
                    4'b0100, 1'b0, 2'd0, 16'h0007, 4'h0, 16'd1};
        vecs[3] = '{4'b0100, {16'h0, 16'hFFFF, 32'h0}, {16'h0, 16'h0001, 32'h0}, 1'b1,
                    4'b0100, 1'b1, 2'd2, 16'h8000, 4'b1010, 16'd2};
        vecs[4] = '{4'b0100, {16'h0, 16'h8000, 32'h0}, {16'h0, 16'h8000, 32'h0}, 1'b1,
                    4'b0100, 1'b1, 2'd2, 16'h0000, 4'b0101, 16'd3};
        vecs[5] = '{4'b0000, 64'h0, 64'h0, 1'b1,
                    4'b0000, 1'b1, 2'd2, 16'h0000, 4'b1101, 16'd4};
        vecs[6] = '{4'b0010, {32'h0, 16'h1234, 16'h0}, {32'h0, 16'h4321, 16'h0}, 1'b1,
                    4'b0010, 1'b0, 2'd2, 16'h0000, 4'b1101, 16'd4};
        vecs[7] = '{4'b0001, {48'h0, 16'h8000}, {48'h0, 16'h7FFF}, 1'b1,
                    4'b0001, 1'b1, 2'd1, 16'h5555, 4'b0000, 16'd5};
        vecs[8] = '{4'b0000, 64'h0, 64'h0, 1'b1,
                    4'b0000, 1'b1, 2'd0, 16'hFFFF, 4'b0010, 16'd6};

        // ---------------- reset state ----------------
        do_reset();
        req_valid = 4'b1111;
        #1;
        check("reset.req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = '0;
        #1;
        check_rsp("reset", 1'b0, 2'd0, 16'h0, 4'h0, 16'd0);
        tick();

        // ---------------- table vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            rsp_ready = vecs[i].rr;
            #1;
            check($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            check_rsp($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_id,
                      vecs[i].exp_data, vecs[i].exp_flags, vecs[i].exp_cnt);
            tick();
        end

        // ---------------- round-robin, all valid ----------------
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
        req_b     = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        prev_g    = -1;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % NREQ;
            #1;
            check($sformatf("rr%0d.req_ready", k), 32'(req_ready), 32'(1) << g);
            if (prev_g >= 0) begin
                check($sformatf("rr%0d.rsp_id", k),   32'(rsp_id),   32'(prev_g));
                check($sformatf("rr%0d.rsp_data", k), 32'(rsp_data), 32'(prev_g * 16'h0101));
            end
            prev_g = g;
            tick();
        end
        check("rr.last_id", 32'(rsp_id), 32'd1);
        check("rr.op_count", 32'(op_count), 32'd6);

        // ---------------- backpressure ----------------
        do_reset();
        req_valid = 4'b0001;
        req_a     = {48'h0, 16'h1111};
        req_b     = {48'h0, 16'h2222};
        rsp_ready = 1'b1;
        tick();                                   // accept 0, ptr -> 1
        req_valid = 4'b1010;
        req_a     = {16'hA000, 16'h0, 16'h0102, 16'h0};
        req_b     = {16'h0A00, 16'h0, 16'h0304, 16'h0};
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d.req_ready", k), 32'(req_ready), 32'h0);
            check_rsp($sformatf("bp%0d", k), 1'b1, 2'd0, 16'h3333, 4'h0, 16'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release.req_ready", 32'(req_ready), 32'b0010);
        tick();                                   // consume + accept 1, ptr -> 2
        check_rsp("bp.new", 1'b1, 2'd1, 16'h0406, 4'h0, 16'd2);

        // ---------------- clk_en freeze ----------------
        req_valid = 4'b1000;
        clk_en    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("cen%0d.req_ready", k), 32'(req_ready), 32'h0);
            check_rsp($sformatf("cen%0d", k), 1'b1, 2'd1, 16'h0406, 4'h0, 16'd2);
            tick();
        end
        clk_en = 1'b1;
        #1;
        check("cen.resume.req_ready", 32'(req_ready), 32'b1000);
        tick();                                   // consume + accept 3
        check_rsp("cen.resume", 1'b1, 2'd3, 16'hAA00, 4'b0010, 16'd3);

        // ---------------- asynchronous reset mid-cycle ----------------
        do_reset();
        req_valid = 4'b0010;
        req_a     = {32'h0, 16'h0005, 16'h0};
        req_b     = {32'h0, 16'h0006, 16'h0};
        rsp_ready = 1'b1;
        tick();                                   // accept 1, ptr -> 2
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        check_rsp("arst.before", 1'b1, 2'd1, 16'h000B, 4'h0, 16'd1);
        #1;                                       // well away from any edge
        ASYNCRESET = 1'b1;
        req_valid  = 4'b1111;
        #1;
        check("arst.req_ready", 32'(req_ready), 32'h0);
        check_rsp("arst", 1'b0, 2'd0, 16'h0, 4'h0, 16'd0);
        #1;
        ASYNCRESET = 1'b0;
        req_valid  = 4'b1000;
        rsp_ready  = 1'b1;
        #1;
        check("arst.lone3.req_ready", 32'(req_ready), 32'b1000);
        tick();                                   // accept 3, ptr -> 0
        req_valid = 4'b1111;
        #1;
        check("arst.allvalid.req_ready", 32'(req_ready), 32'b0001);
        held_id   = rsp_id;
        held_data = rsp_data;
        check("arst.lone3.rsp_id", 32'(held_id), 32'd3);
        check("arst.lone3.op_count", 32'(op_count), 32'd1);
        tick();
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
